// File: rtl/mc_cu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_cu_pkg
//  Description : Shared definitions for the multi-cycle control unit: state
//                codes, opcode/func encodings, ALU control, ALU B-select and
//                PC-source codes, the one-hot instruction class record and an
//                ALU-control helper function.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_cu_pkg;

    // FSM state codes (3-bit, codes 5..7 unused)
    localparam logic [2:0] c_st_if  = 3'd0;
    localparam logic [2:0] c_st_id  = 3'd1;
    localparam logic [2:0] c_st_exe = 3'd2;
    localparam logic [2:0] c_st_mem = 3'd3;
    localparam logic [2:0] c_st_wb  = 3'd4;

    // Opcodes
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_xori  = 6'b001110;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;

    // R-type func codes
    localparam logic [5:0] c_fn_add    = 6'b100000;
    localparam logic [5:0] c_fn_sub    = 6'b100010;
    localparam logic [5:0] c_fn_and    = 6'b100100;
    localparam logic [5:0] c_fn_or     = 6'b100101;
    localparam logic [5:0] c_fn_xor    = 6'b100110;
    localparam logic [5:0] c_fn_sll    = 6'b000000;
    localparam logic [5:0] c_fn_srl    = 6'b000010;
    localparam logic [5:0] c_fn_sra    = 6'b000011;
    localparam logic [5:0] c_fn_jr     = 6'b001000;
    localparam logic [5:0] c_fn_lowest = 6'b110000;

    // ALU operation codes
    localparam logic [3:0] c_aluc_add    = 4'b0000;
    localparam logic [3:0] c_aluc_sub    = 4'b0100;
    localparam logic [3:0] c_aluc_and    = 4'b0001;
    localparam logic [3:0] c_aluc_or     = 4'b0101;
    localparam logic [3:0] c_aluc_xor    = 4'b0010;
    localparam logic [3:0] c_aluc_lui    = 4'b0110;
    localparam logic [3:0] c_aluc_sll    = 4'b0011;
    localparam logic [3:0] c_aluc_srl    = 4'b0111;
    localparam logic [3:0] c_aluc_sra    = 4'b1111;
    localparam logic [3:0] c_aluc_lowest = 4'b1011;

    // ALU B-operand select
    localparam logic [1:0] c_alub_reg  = 2'b00;
    localparam logic [1:0] c_alub_imm  = 2'b01;
    localparam logic [1:0] c_alub_four = 2'b10;
    localparam logic [1:0] c_alub_boff = 2'b11;

    // PC source select
    localparam logic [1:0] c_pcs_alu  = 2'b00;
    localparam logic [1:0] c_pcs_btgt = 2'b01;
    localparam logic [1:0] c_pcs_rega = 2'b10;
    localparam logic [1:0] c_pcs_jmp  = 2'b11;

    // One-hot instruction class; all-zero means undecodable
    typedef struct packed {
        logic is_add;
        logic is_sub;
        logic is_and;
        logic is_or;
        logic is_xor;
        logic is_sll;
        logic is_srl;
        logic is_sra;
        logic is_jr;
        logic is_lowest;
        logic is_addi;
        logic is_andi;
        logic is_ori;
        logic is_xori;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_bne;
        logic is_lui;
        logic is_j;
        logic is_jal;
    } inst_t;

    // ALU operation for the register/immediate ALU group
    function automatic logic [3:0] f_aluc(input inst_t c);
        logic [3:0] v;
        v = c_aluc_add;
        if (c.is_sub)               v = c_aluc_sub;
        if (c.is_and  || c.is_andi) v = c_aluc_and;
        if (c.is_or   || c.is_ori)  v = c_aluc_or;
        if (c.is_xor  || c.is_xori) v = c_aluc_xor;
        if (c.is_lui)               v = c_aluc_lui;
        if (c.is_sll)               v = c_aluc_sll;
        if (c.is_srl)               v = c_aluc_srl;
        if (c.is_sra)               v = c_aluc_sra;
        if (c.is_lowest)            v = c_aluc_lowest;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_decode
//  Description : Combinational instruction decoder: op/func -> one-hot
//                instruction class plus an illegal flag.
//  Ports       : i_op, i_func   instruction fields
//                o_inst         one-hot instruction class
//                o_illegal      no supported instruction matched
//  Revision    : 1.0  initial release
// ============================================================================
module mc_decode
    import mc_cu_pkg::*;
#(
    parameter int unsigned EN_LOWEST = 1
) (
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output inst_t      o_inst,
    output logic       o_illegal
);

    always_comb begin
        o_inst = '0;
        case (i_op)
            c_op_rtype: begin
                case (i_func)
                    c_fn_add:    o_inst.is_add    = 1'b1;
                    c_fn_sub:    o_inst.is_sub    = 1'b1;
                    c_fn_and:    o_inst.is_and    = 1'b1;
                    c_fn_or:     o_inst.is_or     = 1'b1;
                    c_fn_xor:    o_inst.is_xor    = 1'b1;
                    c_fn_sll:    o_inst.is_sll    = 1'b1;
                    c_fn_srl:    o_inst.is_srl    = 1'b1;
                    c_fn_sra:    o_inst.is_sra    = 1'b1;
                    c_fn_jr:     o_inst.is_jr     = 1'b1;
                    c_fn_lowest: o_inst.is_lowest = (EN_LOWEST != 0);
                    default:     o_inst           = '0;
                endcase
            end
            c_op_addi: o_inst.is_addi = 1'b1;
            c_op_andi: o_inst.is_andi = 1'b1;
            c_op_ori:  o_inst.is_ori  = 1'b1;
            c_op_xori: o_inst.is_xori = 1'b1;
            c_op_lw:   o_inst.is_lw   = 1'b1;
            c_op_sw:   o_inst.is_sw   = 1'b1;
            c_op_beq:  o_inst.is_beq  = 1'b1;
            c_op_bne:  o_inst.is_bne  = 1'b1;
            c_op_lui:  o_inst.is_lui  = 1'b1;
            c_op_j:    o_inst.is_j    = 1'b1;
            c_op_jal:  o_inst.is_jal  = 1'b1;
            default:   o_inst         = '0;
        endcase
    end

    assign o_illegal = ~(|o_inst);

endmodule
`default_nettype wire

// File: rtl/mc_cu.sv
`default_nettype none
// ============================================================================
//  Module      : mc_cu
//  Description : Multi-cycle CPU control unit (IF/ID/EXE/MEM/WB). Only the
//                state register is sequential; every output is a
//                combinational function of state, op, func, z and mem_ready.
//  Ports       : clock, reset            clock, synchronous active-high reset
//                op, func, z, mem_ready  instruction fields, zero flag, memory
//                                        handshake
//                wpc wir wmem wreg       write enables
//                iord selpc alub aluc    datapath selects / ALU op
//                pcsource regrt m2reg    datapath selects
//                shift sext jal          datapath selects
//                state, illegal          debug state, undecodable pulse
//  Revision    : 1.0  initial release
// ============================================================================
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter int unsigned MEM_WAIT  = 1,
    parameter int unsigned EN_LOWEST = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       selpc,
    output logic [1:0] alub,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic       regrt,
    output logic       m2reg,
    output logic       shift,
    output logic       sext,
    output logic       jal,
    output logic [2:0] state,
    output logic       illegal
);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       w_ready;
    inst_t      w_inst;
    logic       w_dec_illegal;
    logic       w_is_imm;
    logic       w_is_branch;

    generate
        if (MEM_WAIT != 0) begin : g_mem_wait
            assign w_ready = mem_ready;
        end else begin : g_no_mem_wait
            assign w_ready = 1'b1;
        end
    endgenerate

    mc_decode #(
        .EN_LOWEST (EN_LOWEST)
    ) u_decode (
        .i_op      (op),
        .i_func    (func),
        .o_inst    (w_inst),
        .o_illegal (w_dec_illegal)
    );

    assign w_is_imm    = w_inst.is_addi | w_inst.is_andi | w_inst.is_ori |
                         w_inst.is_xori | w_inst.is_lui;
    assign w_is_branch = w_inst.is_beq | w_inst.is_bne;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_if;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = c_st_if;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        selpc    = 1'b0;
        alub     = c_alub_reg;
        aluc     = c_aluc_add;
        pcsource = c_pcs_alu;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        shift    = 1'b0;
        sext     = 1'b0;
        jal      = 1'b0;
        illegal  = 1'b0;

        case (r_state)
            c_st_if: begin
                selpc  = 1'b1;
                alub   = c_alub_four;
                wir    = w_ready;
                wpc    = w_ready;
                w_next = w_ready ? c_st_id : c_st_if;
            end
            c_st_id: begin
                // ALU computes the branch target here; the datapath latches it
                selpc = 1'b1;
                alub  = c_alub_boff;
                if (w_dec_illegal) begin
                    illegal = 1'b1;
                    w_next  = c_st_if;
                end else if (w_inst.is_j || w_inst.is_jal) begin
                    wpc      = 1'b1;
                    pcsource = c_pcs_jmp;
                    wreg     = w_inst.is_jal;
                    jal      = w_inst.is_jal;
                    w_next   = c_st_if;
                end else if (w_inst.is_jr) begin
                    wpc      = 1'b1;
                    pcsource = c_pcs_rega;
                    w_next   = c_st_if;
                end else begin
                    w_next = c_st_exe;
                end
            end
            c_st_exe: begin
                if (w_is_branch) begin
                    aluc     = c_aluc_sub;
                    pcsource = c_pcs_btgt;
                    wpc      = (w_inst.is_beq & z) | (w_inst.is_bne & ~z);
                    w_next   = c_st_if;
                end else if (w_inst.is_lw || w_inst.is_sw) begin
                    alub   = c_alub_imm;
                    sext   = 1'b1;
                    w_next = c_st_mem;
                end else if (!w_dec_illegal) begin
                    aluc   = f_aluc(w_inst);
                    alub   = w_is_imm ? c_alub_imm : c_alub_reg;
                    shift  = w_inst.is_sll | w_inst.is_srl | w_inst.is_sra;
                    sext   = w_inst.is_addi;
                    w_next = c_st_wb;
                end
            end
            c_st_mem: begin
                iord = 1'b1;
                if (w_inst.is_sw) begin
                    wmem   = w_ready;
                    w_next = w_ready ? c_st_if : c_st_mem;
                end else if (w_inst.is_lw) begin
                    w_next = w_ready ? c_st_wb : c_st_mem;
                end
            end
            c_st_wb: begin
                wreg  = 1'b1;
                m2reg = w_inst.is_lw;
                regrt = w_inst.is_lw | w_is_imm;
            end
            default: begin
                w_next = c_st_if;
            end
        endcase

        // Reset abandons the instruction: no architectural write may escape
        if (reset) begin
            wpc     = 1'b0;
            wir     = 1'b0;
            wmem    = 1'b0;
            wreg    = 1'b0;
            illegal = 1'b0;
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: doc/mc_cu.md
MC_CU -- requirements
Module: mc_cu

Interface
REQ-001 Parameter MEM_WAIT, default 1; 1 = honour mem_ready handshake, 0 = mem_ready ignored and treated as 1.
REQ-002 Parameter EN_LOWEST, default 1; 1 = R-type func 110000 ("lowest") is decoded, 0 = it is illegal.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op, func  input  6 each  instruction fields from IR.
REQ-006 z  input  1  ALU zero flag from the current cycle.
REQ-007 mem_ready  input  1  memory has completed the current access this cycle.
REQ-008 wpc, wir, wmem, wreg  output  1 each  write enables for PC, IR, data memory and register file.
REQ-009 iord  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 selpc  output  1  ALU A select: 1 = PC, 0 = register A.
REQ-011 alub  output  2  ALU B select: 00 = reg B, 01 = extended imm, 10 = constant 4, 11 = sext(imm)<<2.
REQ-012 aluc  output  4  ALU op: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111, lowest 1011.
REQ-013 pcsource  output  2  00 = ALU (PC+4), 01 = branch-target register, 10 = register A (jr), 11 = jump address.
REQ-014 regrt, m2reg, shift, sext, jal  output  1 each  same meaning as the single-cycle control unit.
REQ-015 state  output  3  current state, for debug.
REQ-016 illegal  output  1  one-cycle pulse on an undecodable instruction.

Function
REQ-017 Supported set: add sub and or xor sll srl sra jr lowest addi andi ori xori lw sw beq bne lui j jal.
REQ-018 States: IF=0, ID=1, EXE=2, MEM=3, WB=4; codes 5-7 SHALL return to IF on the next edge with all write enables 0.
REQ-019 IF: iord=0, selpc=1, alub=10, aluc=add, pcsource=00; wir=wpc=mem_ready; advance to ID only when mem_ready, else hold IF.
REQ-020 ID: selpc=1, alub=11, aluc=add (branch target latched by datapath); decode op/func.
REQ-021 ID, j/jal/jr: wpc=1, pcsource=11 (j, jal) or 10 (jr); jal additionally wreg=1, jal=1; next IF.
REQ-022 ID, illegal encoding: illegal=1, no write enable asserted, next IF (PC already advanced).
REQ-023 ID, all other instructions: next EXE.
REQ-024 EXE, beq/bne: aluc=sub, alub=00, selpc=0, pcsource=01, wpc=(beq&z)|(bne&~z); next IF.
REQ-025 EXE, lw/sw: aluc=add, alub=01, sext=1; next MEM.
REQ-026 EXE, R-type/I-type ALU: aluc per REQ-012, alub=01 for immediates else 00, shift for sll/srl/sra, sext for addi only; next WB.
REQ-027 MEM: iord=1; sw: wmem=mem_ready, next IF when mem_ready; lw: next WB when mem_ready; otherwise hold MEM with wmem=0.
REQ-028 WB: wreg=1; lw: m2reg=1, regrt=1; I-type: regrt=1; next IF.
REQ-029 Unused outputs in any state SHALL be 0; wmem, wreg, wpc, wir SHALL never be asserted outside the states above.
REQ-030 With MEM_WAIT=0, IF and MEM each last exactly one cycle: lw 5, sw/ALU 4, branch 3, jump 2 cycles.
REQ-031 All outputs SHALL be combinational functions of state, op, func, z, mem_ready; only state is registered.

Reset
REQ-032 reset sampled high at a rising edge SHALL force state=IF; while reset is high all write enables and illegal SHALL be 0.
REQ-033 Reset mid-instruction (any state, including a stalled MEM) SHALL abandon the instruction without a register or memory write.

Structure
REQ-034 Shared package mc_cu_pkg: state codes, opcode/func constants, aluc, alub and pcsource codes.
REQ-035 One sub-module mc_decode: combinational op/func -> one-hot instruction class plus illegal flag.

Verification
REQ-036 Reset high 2 cycles then add (op 0, func 100000), MEM_WAIT=0 -> states 0,1,2,4,0; wreg=1 only in WB; aluc=0000.
REQ-037 lw (op 100011) with mem_ready low 3 cycles in MEM -> MEM held 3 cycles, wreg=0 throughout, then WB with m2reg=1.
REQ-038 beq (op 000100) with z=1 -> wpc=1, pcsource=01 in EXE; with z=0 -> wpc=0; both return to IF.
REQ-039 jal (op 000011) -> ID asserts wpc, wreg, jal, pcsource=11; next state IF; 2-cycle instruction.
REQ-040 op 111111, and func 110000 with EN_LOWEST=0 -> illegal pulse in ID, no write enables, next IF.
REQ-041 sw with reset asserted in MEM while mem_ready=1 -> wmem=0, state=IF after the edge.
